// File: rtl/key_repeat_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_repeat_if
//  Description : Key/command signal bundle between the button front end,
//                the VGA frame-tick source and the grid controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface key_repeat_if;
    logic [3:0] key_sw;       // raw asynchronous buttons
    logic       draw_finish;  // one-clk frame tick
    logic [3:0] op_keys;      // one-clk command pulses
    logic [3:0] held_keys;    // debounced key levels

    // Side that owns the buttons and the frame tick.
    modport master (
        output key_sw,
        output draw_finish,
        input  op_keys,
        input  held_keys
    );

    // Side that turns buttons into command pulses.
    modport slave (
        input  key_sw,
        input  draw_finish,
        output op_keys,
        output held_keys
    );
endinterface
`default_nettype wire

// File: rtl/key_repeat_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : key_repeat_ctrl
//  Description : Synchronizes and debounces four push buttons, emits a
//                one-clk command pulse per press, auto-repeats keys 1..3
//                on frame ticks while held, and serializes simultaneous
//                events through a fixed-priority arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_repeat_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12,
    parameter int unsigned REPEAT_RATE     = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    key_repeat_if.slave bus
);

    localparam logic [17:0] c_deb_last = 18'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]  c_delay    = 6'(REPEAT_DELAY);
    localparam logic [5:0]  c_rate     = 6'(REPEAT_RATE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [17:0] r_deb_cnt [4];
    logic [3:0]  r_held;
    logic [3:0]  r_held_prev;
    logic [3:0]  r_pending;
    logic [3:0]  r_op;

    // Auto-repeat FSMs exist only for keys 1..3; key 0 (rotate) never repeats.
    rep_state_t  r_state     [1:3];
    rep_state_t  w_state_nxt [1:3];
    logic [5:0]  r_fcnt      [1:3];
    logic [5:0]  w_fcnt_nxt  [1:3];
    logic [5:0]  w_fcnt_inc;

    logic [3:0]  w_rise;
    logic [3:0]  w_rep_evt;
    logic [3:0]  w_new_evt;
    logic [3:0]  w_grant;

    // Two-flop synchronizer on the raw buttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.key_sw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-key debounce: a level must differ from the accepted level for
    // DEBOUNCE_CYCLES consecutive edges before it is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_held <= '0;
            for (int k = 0; k < 4; k++) begin
                r_deb_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (r_sync2[k] == r_held[k]) begin
                    r_deb_cnt[k] <= '0;
                end else if (r_deb_cnt[k] == c_deb_last) begin
                    r_held[k]    <= r_sync2[k];
                    r_deb_cnt[k] <= '0;
                end else begin
                    r_deb_cnt[k] <= r_deb_cnt[k] + 18'd1;
                end
            end
        end
    end

    // Previous accepted level, used to spot press (0->1) transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_held_prev <= '0;
        end else begin
            r_held_prev <= r_held;
        end
    end

    // Repeat FSM state and frame-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k < 4; k++) begin
                r_state[k] <= ST_IDLE;
                r_fcnt[k]  <= '0;
            end
        end else begin
            for (int k = 1; k < 4; k++) begin
                r_state[k] <= w_state_nxt[k];
                r_fcnt[k]  <= w_fcnt_nxt[k];
            end
        end
    end

    // Repeat FSM next-state logic; a released key always wins over a tick.
    always_comb begin
        w_rep_evt  = '0;
        w_fcnt_inc = '0;
        for (int k = 1; k < 4; k++) begin
            w_state_nxt[k] = r_state[k];
            w_fcnt_nxt[k]  = r_fcnt[k];
        end
        for (int k = 1; k < 4; k++) begin
            w_fcnt_inc = r_fcnt[k] + 6'd1;
            if (!r_held[k]) begin
                w_state_nxt[k] = ST_IDLE;
                w_fcnt_nxt[k]  = '0;
            end else begin
                case (r_state[k])
                    ST_IDLE: begin
                        w_state_nxt[k] = ST_DELAY;
                        w_fcnt_nxt[k]  = '0;
                    end
                    ST_DELAY: begin
                        if (bus.draw_finish) begin
                            if (w_fcnt_inc == c_delay) begin
                                w_rep_evt[k]   = 1'b1;
                                w_fcnt_nxt[k]  = '0;
                                w_state_nxt[k] = ST_REPEAT;
                            end else begin
                                w_fcnt_nxt[k] = w_fcnt_inc;
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (bus.draw_finish) begin
                            if (w_fcnt_inc == c_rate) begin
                                w_rep_evt[k]  = 1'b1;
                                w_fcnt_nxt[k] = '0;
                            end else begin
                                w_fcnt_nxt[k] = w_fcnt_inc;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt[k] = ST_IDLE;
                        w_fcnt_nxt[k]  = '0;
                    end
                endcase
            end
        end
    end

    // Press events plus repeat events; grant isolates the lowest set bit.
    assign w_rise    = r_held & ~r_held_prev;
    assign w_new_evt = w_rise | w_rep_evt;
    assign w_grant   = r_pending & (~r_pending + 4'd1);

    // Arbiter: issue one pulse per cycle; an event arriving for the key
    // being granted stays pending and produces a later second pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_op      <= '0;
        end else begin
            r_pending <= (r_pending & ~w_grant) | w_new_evt;
            r_op      <= w_grant;
        end
    end

    assign bus.op_keys   = r_op;
    assign bus.held_keys = r_held;

endmodule
`default_nettype wire

// File: tb/tb_key_repeat_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_repeat_ctrl
//  Description : Directed plus randomized bench for key_repeat_ctrl with a
//                cycle-level behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_repeat_ctrl;

    localparam int DEB = 4;
    localparam int RD  = 3;
    localparam int RR  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_repeat_if kif();

    key_repeat_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (kif.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    endtask

    // Reference model: sync delay line, run length of disagreement,
    // frames seen since press, and a set of outstanding events.
    bit [3:0] m_s1, m_s2, m_held, m_hprev, m_pend, m_op;
    int       m_run   [4];
    int       m_ticks [4];   // -1 while the key is not held

    function automatic void model_clear();
        m_s1 = '0; m_s2 = '0; m_held = '0; m_hprev = '0; m_pend = '0; m_op = '0;
        for (int k = 0; k < 4; k++) begin
            m_run[k]   = 0;
            m_ticks[k] = -1;
        end
    endfunction

    function automatic void model_step(input bit [3:0] ks, input bit df);
        bit [3:0] ev;
        bit [3:0] g;
        ev = m_held & ~m_hprev;
        for (int k = 1; k < 4; k++) begin
            if (!m_held[k]) m_ticks[k] = -1;
            else if (m_ticks[k] < 0) m_ticks[k] = 0;
            else if (df) begin
                m_ticks[k]++;
                if (m_ticks[k] == RD || (m_ticks[k] > RD && (m_ticks[k] - RD) % RR == 0))
                    ev[k] = 1'b1;
            end
        end
        g = '0;
        for (int k = 0; k < 4; k++) begin
            if (m_pend[k] && g == '0) g[k] = 1'b1;
        end
        m_op    = g;
        m_pend  = (m_pend & ~g) | ev;
        m_hprev = m_held;
        for (int k = 0; k < 4; k++) begin
            if (m_s2[k] != m_held[k]) begin
                if (m_run[k] == DEB - 1) begin
                    m_held[k] = m_s2[k];
                    m_run[k]  = 0;
                end else begin
                    m_run[k]++;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = ks;
    endfunction

    // Advance the model on every edge and compare just after it.
    always @(posedge clk) begin
        if (rst) model_clear();
        else     model_step(kif.key_sw, kif.draw_finish);
        #1;
        check("op_keys",   32'(kif.op_keys),   32'(m_op));
        check("held_keys", 32'(kif.held_keys), 32'(m_held));
        check("op_onehot", 32'($countones(kif.op_keys) <= 1), 32'd1);
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        bit found;
        int pulses;
        kif.key_sw      = '0;
        kif.draw_finish = 1'b0;
        model_clear();
        idle(3);
        rst = 1'b0;

        // Rotate key held with frame ticks: one pulse only.
        kif.key_sw = 4'b0001;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            kif.draw_finish = (i % 3 == 0);
            @(negedge clk);
            if (kif.op_keys[0]) pulses++;
        end
        check("rotate_pulse_count", 32'(pulses), 32'd1);
        kif.key_sw = '0; kif.draw_finish = 1'b0;
        idle(10);

        // Short glitch on key 2.
        kif.key_sw = 4'b0100;
        idle(3);
        kif.key_sw = '0;
        idle(10);
        check("glitch_held", 32'(kif.held_keys), 32'd0);

        // Key 2 held with a tick every 10 clocks, then released.
        kif.key_sw = 4'b0100;
        pulses = 0;
        for (int i = 0; i < 120; i++) begin
            kif.draw_finish = (i % 10 == 9);
            @(negedge clk);
            if (kif.op_keys[2]) pulses++;
        end
        check("left_repeat_count", 32'(pulses), 32'd6);
        kif.key_sw = '0; kif.draw_finish = 1'b0;
        idle(20);

        // All four keys at once.
        kif.key_sw = 4'b1111;
        idle(20);
        kif.key_sw = '0;
        idle(10);

        // Reset one edge after held_keys reaches 0110.
        kif.key_sw = 4'b0110;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (kif.held_keys == 4'b0110) found = 1'b1;
        end
        check("wait_held_0110", 32'(found), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check("rst_op_now",   32'(kif.op_keys),   32'd0);
        check("rst_held_now", 32'(kif.held_keys), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(20);
        kif.key_sw = '0;
        idle(10);

        // Randomized keys, ticks and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) kif.key_sw = 4'($urandom);
            kif.draw_finish = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                model_clear();
            end else begin
                rst = 1'b0;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        kif.key_sw = '0; kif.draw_finish = 1'b0;
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
